// File: rtl/poly_ctrl.sv
// Moore control sequencer for the X/S/H accumulator datapath: evaluates y = (A*x + B)*x + C.
// Optional single-step mode is enabled by defining POLY_CTRL_STEP_EN.
module poly_ctrl #(
    parameter int XW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x_in,
    input  logic          step,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x_out,
    output logic [1:0]    sel_k,
    output logic [1:0]    sel_a,
    output logic [1:0]    sel_b,
    output logic          sub,
    output logic          ld_x,
    output logic          ld_s,
    output logic          ld_h
);

    typedef enum logic [3:0] {
        S_IDLE, S_LDX, S_CLRS, S_MULA, S_ADDB, S_MOVH, S_CLRS2, S_MULH, S_ADDC, S_DONE
    } state_t;

    state_t        state, nxt;
    logic [XW-1:0] xr, cnt;
    logic          adv;

    logic          busy_d, done_d, ldx_d, lds_d, ldh_d;
    logic [XW-1:0] xo_d;
    logic [1:0]    sk_d, sa_d, sb_d;
    logic          ldx_q, lds_q, ldh_q;

`ifdef POLY_CTRL_STEP_EN
    assign adv = (state == S_IDLE) || step;
`else
    logic unused_step;
    assign unused_step = step;
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_LDX;
            S_LDX:   if (adv) nxt = S_CLRS;
            S_CLRS:  if (adv) nxt = (xr != '0) ? S_MULA : S_ADDB;
            S_MULA:  if (adv && cnt <= XW'(1)) nxt = S_ADDB;
            S_ADDB:  if (adv) nxt = S_MOVH;
            S_MOVH:  if (adv) nxt = S_CLRS2;
            S_CLRS2: if (adv) nxt = (xr != '0) ? S_MULH : S_ADDC;
            S_MULH:  if (adv && cnt <= XW'(1)) nxt = S_ADDC;
            S_ADDC:  if (adv) nxt = S_DONE;
            S_DONE:  if (adv) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Operand capture and loop counter; the counter runs x iterations per multiply loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr  <= '0;
            cnt <= '0;
        end else begin
            if (state == S_IDLE && start) xr <= x_in;
            if (adv) begin
                case (state)
                    S_CLRS, S_CLRS2: cnt <= xr;
                    S_MULA, S_MULH:  cnt <= cnt - XW'(1);
                    default:         cnt <= cnt;
                endcase
            end
        end
    end

    // Control word is decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        busy_d = (nxt != S_IDLE);
        done_d = 1'b0;
        xo_d   = '0;
        sk_d   = 2'b00;
        sa_d   = 2'b00;
        sb_d   = 2'b00;
        ldx_d  = 1'b0;
        lds_d  = 1'b0;
        ldh_d  = 1'b0;
        case (nxt)
            S_LDX: begin
                ldx_d = 1'b1;
                xo_d  = (state == S_IDLE) ? x_in : xr;
            end
            S_CLRS, S_CLRS2: begin
                sb_d  = 2'b01;
                lds_d = 1'b1;
            end
            S_MULA, S_ADDB, S_ADDC: begin
                sa_d  = 2'b10;
                sb_d  = 2'b01;
                sk_d  = (nxt == S_MULA) ? 2'b01 : (nxt == S_ADDB) ? 2'b10 : 2'b11;
                lds_d = 1'b1;
            end
            S_MOVH: begin
                sa_d  = 2'b10;
                sb_d  = 2'b01;
                ldh_d = 1'b1;
            end
            S_MULH: begin
                sa_d  = 2'b10;
                sb_d  = 2'b11;
                lds_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            x_out <= '0;
            sel_k <= 2'b00;
            sel_a <= 2'b00;
            sel_b <= 2'b00;
            ldx_q <= 1'b0;
            lds_q <= 1'b0;
            ldh_q <= 1'b0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            x_out <= xo_d;
            sel_k <= sk_d;
            sel_a <= sa_d;
            sel_b <= sb_d;
            ldx_q <= ldx_d;
            lds_q <= lds_d;
            ldh_q <= ldh_d;
        end
    end

    // Loads only reach the datapath on cycles where the FSM will actually advance.
    assign sub  = 1'b0;
    assign ld_x = ldx_q & adv;
    assign ld_s = lds_q & adv;
    assign ld_h = ldh_q & adv;

endmodule
